// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank.
// The frame is one command byte {rw, addr} followed by an unlimited burst of data bytes.
package spi_reg_pkg;

    typedef enum logic {
        CMD  = 1'b0,
        DATA = 1'b1
    } state_e;

    localparam int             BYTE_W      = 8;
    localparam int             RW_BIT      = BYTE_W - 1;
    localparam int             ADDR_ID     = 0;
    localparam logic [BYTE_W-1:0] DEF_CHIP_ID = 8'hA6;

endpackage

// File: rtl/spi_reg_bank_cell.sv
// One configuration register: read-only view of core status, or storage reset either
// by the global reset or, for frame-pulse registers, by every chip-select deassert.
module spi_reg_cell
    import spi_reg_pkg::*;
#(
    parameter int                DATA_W  = BYTE_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter logic [DATA_W-1:0] MASK    = '1,
    parameter bit                RO      = 1'b0,
    parameter bit                PULSE   = 1'b0
) (
    input  logic              spi_clk,
    input  logic              full_rstn,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] ro_data,
    output logic [DATA_W-1:0] value
);

    generate
        if (RO) begin : g_ro
            logic unused_ok;
            assign unused_ok = ^{spi_clk, full_rstn, rstn, wr_en, wr_data};
            assign value     = ro_data & MASK;
        end else begin : g_rw
            logic [DATA_W-1:0] store;
            logic              cell_rstn;
            logic              unused_ok;

            assign unused_ok = ^ro_data;
            assign cell_rstn = PULSE ? full_rstn : rstn;

            // NOTE: each register gets its own reset here; a register file is never
            // reset through a loop in one block, so every cell stays a plain flop.
            always_ff @(posedge spi_clk or negedge cell_rstn) begin
                if (!cell_rstn) begin
                    store <= RST_VAL;
                end else if (wr_en) begin
                    store <= wr_data;
                end
            end

            assign value = store & MASK;
        end
    endgenerate

endmodule

// File: rtl/spi_reg_bank.sv
// SPI slave register bank: deserialises command/address/data bytes MSB first, commits
// writes to the register cells and streams read data back on poci_spi with auto-increment.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                         NUM_REGS   = 9,
    parameter int                         DATA_W     = 8,
    parameter int                         ADDR_W     = 7,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS   = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] WIDTH_MASK = '1,
    parameter logic [NUM_REGS-1:0]        RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0]        PULSE_MASK = '0,
    parameter logic [DATA_W-1:0]          CHIP_ID    = DEF_CHIP_ID
) (
    input  logic                         spi_clk,
    input  logic                         full_rstn,
    input  logic                         rstn,
    input  logic                         pico_spi,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         wr_err,
    output logic                         poci_spi
);

    localparam int CNT_W = $clog2(DATA_W);

    state_e            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] shift;
    logic              rw;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] rd_shadow;

    logic [DATA_W-1:0]   byte_in;
    logic                boundary;
    logic                write_hit;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_val;
    logic [NUM_REGS-1:0] wr_en;

    assign byte_in   = {shift, pico_spi};
    assign boundary  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign write_hit = (state == DATA) && rw && boundary;

    // In CMD the shadow preloads the addressed register; in DATA it prefetches the next one.
    assign rd_addr = (state == CMD) ? byte_in[ADDR_W-1:0] : cur_addr + 1'b1;

    // NOTE: every signal driven in always_comb takes a default first, so no latch can form.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en[i] = write_hit && !RO_MASK[i] && (cur_addr == ADDR_W'(i + 1));
        end
    end

    always_comb begin
        rd_val = '0;
        if (rd_addr == ADDR_W'(ADDR_ID)) begin
            rd_val = CHIP_ID;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i + 1)) begin
                rd_val = regs_o[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: all frame state updates use non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge spi_clk or negedge full_rstn) begin
        if (!full_rstn) begin
            state     <= CMD;
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            cur_addr  <= '0;
            rd_shadow <= '0;
            wr_strobe <= '0;
            wr_err    <= 1'b0;
        end else begin
            bit_cnt   <= boundary ? '0 : bit_cnt + 1'b1;
            shift     <= byte_in[DATA_W-2:0];
            wr_strobe <= wr_en;
            if (write_hit && !(|wr_en)) begin
                wr_err <= 1'b1;
            end
            if (boundary) begin
                if (state == CMD) begin
                    rw       <= byte_in[DATA_W-1];
                    cur_addr <= byte_in[ADDR_W-1:0];
                    state    <= DATA;
                    if (!byte_in[DATA_W-1]) begin
                        rd_shadow <= rd_val;
                    end
                end else begin
                    cur_addr <= cur_addr + 1'b1;
                    if (!rw) begin
                        rd_shadow <= rd_val;
                    end
                end
            end
        end
    end

    assign poci_spi = (state == DATA && !rw) ? rd_shadow[CNT_W'(DATA_W - 1) - bit_cnt] : 1'b0;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            spi_reg_cell #(
                .DATA_W  (DATA_W),
                .RST_VAL (RST_VALS[i*DATA_W +: DATA_W]),
                .MASK    (WIDTH_MASK[i*DATA_W +: DATA_W]),
                .RO      (RO_MASK[i]),
                .PULSE   (PULSE_MASK[i])
            ) u_cell (
                .spi_clk   (spi_clk),
                .full_rstn (full_rstn),
                .rstn      (rstn),
                .wr_en     (wr_en[i]),
                .wr_data   (byte_in),
                .ro_data   (ro_data[i*DATA_W +: DATA_W]),
                .value     (regs_o[i*DATA_W +: DATA_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: ten registers (reg1 6-bit, reg3 frame-pulse, reg10 read-only),
// bit-level SPI master, register model and a read-data scoreboard.
module tb_spi_reg_bank;

    localparam int NREG = 10;
    localparam logic [NREG*8-1:0] RST_P  = {8'h00, 8'h01, 8'h00, 8'h00, 8'h02,
                                            8'hff, 8'h03, 8'h00, 8'hff, 8'h3f};
    localparam logic [NREG*8-1:0] MASK_P = {{9{8'hff}}, 8'h3f};
    localparam logic [NREG-1:0]   RO_P   = 10'b10_0000_0000;
    localparam logic [NREG-1:0]   PULSE_P = 10'b00_0000_0100;
    localparam logic [NREG*8-1:0] RO_DATA_P = {8'h01, {9{8'h5a}}};

    logic              spi_clk;
    logic              rstn;
    logic              cs;
    logic              full_rstn;
    logic              pico_spi;
    logic [NREG*8-1:0] ro_data;
    logic [NREG*8-1:0] regs_o;
    logic [NREG-1:0]   wr_strobe;
    logic              wr_err;
    logic              poci_spi;

    assign full_rstn = rstn & cs;

    spi_reg_bank #(
        .NUM_REGS   (NREG),
        .DATA_W     (8),
        .ADDR_W     (7),
        .RST_VALS   (RST_P),
        .WIDTH_MASK (MASK_P),
        .RO_MASK    (RO_P),
        .PULSE_MASK (PULSE_P),
        .CHIP_ID    (8'hA6)
    ) dut (
        .spi_clk   (spi_clk),
        .full_rstn (full_rstn),
        .rstn      (rstn),
        .pico_spi  (pico_spi),
        .ro_data   (ro_data),
        .regs_o    (regs_o),
        .wr_strobe (wr_strobe),
        .wr_err    (wr_err),
        .poci_spi  (poci_spi)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    int unsigned     n_checks = 0;
    int unsigned     n_fails  = 0;
    logic [7:0]      exp_reg [1:NREG];
    logic            exp_err;
    logic [NREG-1:0] exp_strobe;
    logic [7:0]      wbuf [$];
    logic [7:0]      sb [$];

    function automatic logic [7:0] mask_of(input int a);
        return MASK_P[(a-1)*8 +: 8];
    endfunction

    function automatic void mdl_reset_all();
        for (int i = 1; i <= NREG; i++) begin
            exp_reg[i] = RO_P[i-1] ? (RO_DATA_P[(i-1)*8 +: 8] & mask_of(i))
                                   : (RST_P[(i-1)*8 +: 8] & mask_of(i));
        end
    endfunction

    function automatic void mdl_frame_end();
        for (int i = 1; i <= NREG; i++) begin
            if (PULSE_P[i-1]) exp_reg[i] = RST_P[(i-1)*8 +: 8] & mask_of(i);
        end
        exp_err = 1'b0;
    endfunction

    function automatic void mdl_write(input int a, input logic [7:0] d);
        exp_strobe = '0;
        if (a >= 1 && a <= NREG && !RO_P[a-1]) begin
            exp_reg[a] = d & mask_of(a);
            exp_strobe[a-1] = 1'b1;
        end else begin
            exp_err = 1'b1;
        end
    endfunction

    function automatic logic [7:0] mdl_read(input int a);
        if (a == 0) return 8'hA6;
        if (a >= 1 && a <= NREG) return exp_reg[a];
        return 8'h00;
    endfunction

    function automatic logic [NREG*8-1:0] mdl_regs();
        logic [NREG*8-1:0] v;
        for (int i = 1; i <= NREG; i++) v[(i-1)*8 +: 8] = exp_reg[i];
        return v;
    endfunction

    // Drives n bits of tx MSB first; poci is captured before each active edge.
    task automatic send_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            pico_spi  = tx[7-i];
            rx[7-i]   = poci_spi;
            @(posedge spi_clk);
            #1;
        end
    endtask

    task automatic check_regs(input string name);
        n_checks++;
        if (regs_o !== mdl_regs()) begin
            n_fails++;
            $display("FAIL %s regs_o got %h expected %h", name, regs_o, mdl_regs());
        end
    endtask

    task automatic begin_frame();
        @(posedge spi_clk);
        #1;
        cs = 1'b1;
    endtask

    task automatic end_frame();
        cs = 1'b0;
        @(posedge spi_clk);
        #1;
        mdl_frame_end();
        check_regs("frame_end");
        n_checks++;
        if (wr_err !== 1'b0 || wr_strobe !== '0 || poci_spi !== 1'b0) begin
            n_fails++;
            $display("FAIL frame_end err/strobe/poci got %b/%b/%b expected 0/0/0",
                     wr_err, wr_strobe, poci_spi);
        end
    endtask

    task automatic write_burst(input logic [6:0] addr);
        logic [6:0] a;
        logic [7:0] rx;
        a = addr;
        begin_frame();
        send_bits({1'b1, addr}, 8, rx);
        foreach (wbuf[k]) begin
            send_bits(wbuf[k], 8, rx);
            mdl_write(int'(a), wbuf[k]);
            n_checks++;
            if (wr_strobe !== exp_strobe) begin
                n_fails++;
                $display("FAIL wr_strobe addr %0d got %b expected %b", a, wr_strobe, exp_strobe);
            end
            n_checks++;
            if (wr_err !== exp_err) begin
                n_fails++;
                $display("FAIL wr_err addr %0d got %b expected %b", a, wr_err, exp_err);
            end
            check_regs("write_burst");
            a = a + 1'b1;
        end
    endtask

    task automatic read_burst(input logic [6:0] addr, input int n);
        logic [6:0] a;
        logic [7:0] rx;
        logic [7:0] exp;
        a = addr;
        begin_frame();
        for (int k = 0; k < n; k++) begin
            sb.push_back(mdl_read(int'(a)));
            a = a + 1'b1;
        end
        send_bits({1'b0, addr}, 8, rx);
        for (int k = 0; k < n; k++) begin
            send_bits(8'h00, 8, rx);
            exp = sb.pop_front();
            n_checks++;
            if (rx !== exp) begin
                n_fails++;
                $display("FAIL read addr %0d byte %0d got %h expected %h", addr, k, rx, exp);
            end
        end
        end_frame();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge spi_clk);
        #1;
        mdl_reset_all();
        exp_err = 1'b0;
        check_regs("reset");
        n_checks++;
        if (wr_err !== 1'b0 || wr_strobe !== '0 || poci_spi !== 1'b0) begin
            n_fails++;
            $display("FAIL reset err/strobe/poci got %b/%b/%b expected 0/0/0",
                     wr_err, wr_strobe, poci_spi);
        end
        rstn = 1'b1;
        read_burst(7'd1, 9);
    endtask

    task automatic test_single_write();
        wbuf = '{8'h15};
        write_burst(7'd2);
        @(posedge spi_clk);
        #1;
        n_checks++;
        if (wr_strobe !== '0) begin
            n_fails++;
            $display("FAIL strobe_width got %b expected 0", wr_strobe);
        end
        end_frame();
    endtask

    task automatic test_burst_write();
        wbuf = '{8'haa, 8'hbb, 8'hcc};
        write_burst(7'd8);
        end_frame();
        read_burst(7'd8, 3);
    endtask

    task automatic test_read_special();
        read_burst(7'd0, 1);
        read_burst(7'd10, 1);
        read_burst(7'd100, 1);
        read_burst(7'd127, 3);
    endtask

    task automatic test_pulse_mask();
        wbuf = '{8'hff, 8'h2b, 8'h02};
        write_burst(7'd1);
        end_frame();
        read_burst(7'd1, 3);
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        begin_frame();
        send_bits(8'h84, 8, rx);
        send_bits(8'hf0, 4, rx);
        n_checks++;
        if (wr_strobe !== '0) begin
            n_fails++;
            $display("FAIL partial strobe got %b expected 0", wr_strobe);
        end
        check_regs("partial");
        end_frame();
        read_burst(7'd4, 1);
        wbuf = '{8'h5c};
        write_burst(7'd4);
        end_frame();
    endtask

    task automatic test_rstn();
        wbuf = '{8'h77, 8'hd4};
        write_burst(7'd1);
        end_frame();
        rstn = 1'b0;
        @(posedge spi_clk);
        #1;
        mdl_reset_all();
        check_regs("rstn");
        rstn = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [6:0] start;
        for (int it = 0; it < 4; it++) begin
            start = 7'($urandom_range(1, 9));
            wbuf = '{8'($urandom), 8'($urandom), 8'($urandom)};
            write_burst(start);
            end_frame();
            read_burst(start, 4);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        cs       = 1'b0;
        pico_spi = 1'b0;
        ro_data  = RO_DATA_P;
        test_reset();
        test_single_write();
        test_burst_write();
        test_read_special();
        test_pulse_mask();
        test_partial();
        test_rstn();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
